// File: rtl/bcd_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the serial BCD adder.
// The requester drives start/operands; the adder returns status and result.
interface bcd_serial_adder_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                start;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                cin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] sum;
    logic                cout;
    logic                error;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, error
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, error
    );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first,
// built around a single shared digit-adder stage.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic clk,
    input  logic rst_n,
    bcd_serial_adder_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [3:0] ad, bd, dig;
    logic [4:0] raw;
    logic       gt9, bad, last;

    // Shared digit stage: operand digits selected by the current index
    always_comb begin
        ad   = 4'(a_q >> {idx_q, 2'b00});
        bd   = 4'(b_q >> {idx_q, 2'b00});
        raw  = 5'(ad) + 5'(bd) + 5'(carry_q);
        gt9  = raw > 5'd9;
        dig  = gt9 ? 4'(raw - 5'd10) : raw[3:0];
        bad  = (ad > 4'd9) || (bd > 4'd9);
        last = idx_q == IW'(DIGITS - 1);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (bad) begin
                    err_d   = 1'b1;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    carry_d = gt9;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (IW'(i) == idx_q) sum_d[4*i +: 4] = dig;
                    end
                    if (last) begin
                        cout_d  = gt9;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy  = state_q != S_IDLE;
    assign bus.done  = state_q == S_DONE;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.error = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Bench for the serial BCD adder: 2- and 4-digit instances, scoreboard
// of decimal-model results checked when done pulses.
module tb_bcd_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_serial_adder_ctrl_if #(.DIGITS(2)) if2 ();
    bcd_serial_adder_ctrl_if #(.DIGITS(4)) if4 ();

    bcd_serial_adder_ctrl #(.DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic sel4   = 1'b0;

    logic        c_done, c_busy, c_cout, c_err;
    logic [31:0] c_sum;
    always_comb begin
        c_done = sel4 ? if4.done  : if2.done;
        c_busy = sel4 ? if4.busy  : if2.busy;
        c_cout = sel4 ? if4.cout  : if2.cout;
        c_err  = sel4 ? if4.error : if2.error;
        c_sum  = sel4 ? 32'(if4.sum) : 32'(if2.sum);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Decimal reference: digits to integers, add, back to BCD
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input int d,
                         output logic [31:0] s, output logic co,
                         output logic er, output int lat);
        longint av = 0, bv = 0, tot, pw = 1;
        er  = 1'b0;
        lat = d;
        s   = '0;
        for (int i = 0; i < d; i++) begin
            if (!er && (a[4*i +: 4] > 9 || b[4*i +: 4] > 9)) begin
                er  = 1'b1;
                lat = i + 1;
            end
        end
        for (int i = d - 1; i >= 0; i--) begin
            av = av * 10 + longint'(a[4*i +: 4]);
            bv = bv * 10 + longint'(b[4*i +: 4]);
            pw = pw * 10;
        end
        tot = av + bv + longint'(cin);
        co  = tot >= pw;
        tot = tot % pw;
        for (int i = 0; i < d; i++) begin
            s[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
        end
        if (er) begin
            s  = '0;
            co = 1'b0;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic st);
        if2.a     = a[7:0];
        if2.b     = b[7:0];
        if2.cin   = cin;
        if4.a     = a[15:0];
        if4.b     = b[15:0];
        if4.cin   = cin;
        if2.start = st && !sel4;
        if4.start = st && sel4;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output int lat);
        exp_t e;
        model(a, b, cin, sel4 ? 4 : 2, e.sum, e.cout, e.err, lat);
        sb.push_back(e);
    endtask

    // Called at the negedge following the accepting edge
    task automatic wait_done(input int exp_lat, input int exp_busy,
                             input string tag);
        int   cyc = 0;
        int   bc  = 0;
        exp_t e;
        while (!c_done && cyc < 40) begin
            if (c_busy) bc++;
            @(negedge clk);
            cyc++;
        end
        if (c_busy) bc++;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        if (exp_busy >= 0) chk({tag, "_busy"}, 32'(bc), 32'(exp_busy));
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, c_sum, e.sum);
            chk({tag, "_cout"}, 32'(c_cout), 32'(e.cout));
            chk({tag, "_err"}, 32'(c_err), 32'(e.err));
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input string tag);
        int          lat;
        logic [31:0] hs;
        push(a, b, cin, lat);
        drive(a, b, cin, 1'b1);
        @(negedge clk);
        drive(a, b, cin, 1'b0);
        wait_done(lat, lat + 1, tag);
        hs = c_sum;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(c_done), 32'd0);
        chk({tag, "_hold"}, c_sum, hs);
    endtask

    initial begin
        int          lat;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        drive(0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'({if2.busy, if4.busy}), 32'd0);
        chk("rst_done", 32'({if2.done, if4.done}), 32'd0);
        chk("rst_sum", 32'({if2.sum, if4.sum}), 32'd0);
        chk("rst_cout_err", 32'({if2.cout, if2.error, if4.cout, if4.error}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(32'h45, 32'h38, 1'b0, "t1");
        op(32'h99, 32'h99, 1'b1, "t2a");
        op(32'h50, 32'h50, 1'b0, "t2b");
        op(32'h00, 32'h00, 1'b0, "t2c");
        op(32'h1A, 32'h01, 1'b0, "t3a");
        op(32'h17, 32'hB2, 1'b0, "t3b");

        // start pulsed during ADD and DONE with other operands is ignored
        push(32'h45, 32'h38, 1'b0, lat);
        drive(32'h45, 32'h38, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h11, 32'h22, 1'b1, 1'b1);
        wait_done(2, 3, "t4ign");
        drive(32'h11, 32'h22, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4ign_nodone", 32'(c_done), 32'd0);
        end
        chk("t4ign_keep", c_sum, 32'h83);

        // start held high: back-to-back operations every 4 cycles
        push(32'h27, 32'h36, 1'b0, lat);
        push(32'h27, 32'h36, 1'b0, lat);
        drive(32'h27, 32'h36, 1'b0, 1'b1);
        @(negedge clk);
        wait_done(2, 3, "t4h1");
        @(negedge clk);
        wait_done(3, 3, "t4h2");
        drive(32'h27, 32'h36, 1'b0, 1'b0);
        @(negedge clk);

        // asynchronous reset in the middle of ADD
        drive(32'h45, 32'h38, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h45, 32'h38, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_partial", c_sum, 32'h03);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(if2.busy), 32'd0);
        chk("t5_rst_done", 32'(if2.done), 32'd0);
        chk("t5_rst_sum", 32'(if2.sum), 32'd0);
        chk("t5_rst_ce", 32'({if2.cout, if2.error}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_nodone", 32'(c_done), 32'd0);
        end
        op(32'h12, 32'h09, 1'b0, "t5");

        sel4 = 1'b1;
        @(negedge clk);
        op(32'h9999, 32'h0001, 1'b0, "t6a");
        op(32'h9999, 32'h9999, 1'b1, "t6b");
        op(32'h12A4, 32'h0001, 1'b0, "t6c");
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            ra[31:16] = '0;
            rb[31:16] = '0;
            op(ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequencer that adds two multi-digit packed-BCD operands one digit per clock.
- Uses a single shared digit-adder stage: 4-bit add, >9 compare, −10 correction, carry flip-flop.
- Processes digits least significant first.
- Used on the board to extend the 2-digit switch adder to N digits, and to feed the HEX decoders from registered results.
- Includes start/busy/done handshake and invalid-digit detection.

Parameters:
DIGITS, 2, number of BCD digits per operand (1..8); operand and sum width = 4*DIGITS.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry-in to digit 0
busy  output  1  high in ADD and DONE states
done  output  1  one-cycle pulse when the result is valid
sum  output  4*DIGITS  packed BCD result, registered
cout  output  1  carry out of the top digit, registered
error  output  1  set when an input digit is greater than 9; registered

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, error=0.
  - Internal carry=0, digit index=0.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0.
  - On start=1, capture a, b and cin into internal registers in the same edge.
  - Clear sum, cout and error; set index=0; go to ADD.
- ADD, one digit per cycle at digit index i:
  - Extract ad=A[4i+3:4i] and bd=B[4i+3:4i].
  - If ad>9 or bd>9: set error=1, force sum=0 and cout=0, go to DONE. Remaining digits are not processed.
  - Otherwise: raw = ad + bd + carry, computed 5 bits wide (range 0..19).
  - If raw>9: digit = raw−10 (low 4 bits), carry=1. Else digit = raw, carry=0.
  - Write the digit into sum[4i+3:4i]. Other digits of sum are untouched.
  - If i==DIGITS−1: cout=carry, go to DONE. Else i=i+1.
- DONE:
  - done=1 for exactly this one cycle, busy=1.
  - Next state is IDLE unconditionally.
- Latency:
  - start sampled at edge k; done is high in the cycle after edge k+DIGITS.
  - With an error at digit j, done is high after edge k+j+1.
- start:
  - Ignored in ADD and DONE; no queuing.
  - If start is held high continuously, the next operation is accepted in the first IDLE cycle. Repeat period is DIGITS+2 cycles.
- Operand changes while busy have no effect; captured copies are used.
- sum, cout and error hold their values from done until the next accepted start.
- The maximum valid result never overflows the digit width: 99..9 + 99..9 + 1 gives sum all 9s with cout=1.

Test Plan:
1. DIGITS=2, a=0x45, b=0x38, cin=0, start one cycle -> done 2 cycles after the start edge; sum=0x83, cout=0, error=0; busy high for 3 cycles.
2. DIGITS=2, a=0x99, b=0x99, cin=1 -> sum=0x99, cout=1. Also a=0x50, b=0x50, cin=0 -> sum=0x00, cout=1. Also a=0x00, b=0x00 -> sum=0x00, cout=0.
3. DIGITS=2, a=0x1A (digit 0 invalid), b=0x01 -> done 1 cycle after the start edge; error=1, sum=0x00, cout=0. Then a=0x17, b=0xB2 (digit 1 invalid) -> done after 2 cycles, error=1.
4. Pulse start again during ADD and during DONE with different operands -> ignored; the result matches the first operands. Hold start high -> a second done pulse exactly 4 cycles after the first.
5. Assert rst_n=0 asynchronously in the middle of ADD (between clock edges) -> all outputs 0 immediately, no done pulse. After release, a new start of 0x12+0x09 -> sum=0x21.
6. DIGITS=4, a=0x9999, b=0x0001, cin=0 -> done 4 cycles after the start edge; sum=0x0000, cout=1. Random valid-BCD operands compared against a decimal reference model for 1000 iterations.
